// File: rtl/sar_pkg.sv
// Shared types and default parameter values for the SAR ADC controller.
package sar_pkg;

    localparam int unsigned NBITS_DEF      = 8;
    localparam int unsigned SAMPLE_CYC_DEF = 2;
    localparam int unsigned SETTLE_CYC_DEF = 1;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        COMPARE,
        DONE
    } sar_state_t;

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable 4-bit down-counter; tc is high while the count sits at zero.
module sar_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       tc
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 4'd1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample, bitwise DAC trials, and a
// valid/ready result port with a sticky overrun flag.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned NBITS      = NBITS_DEF,
    parameter int unsigned SAMPLE_CYC = SAMPLE_CYC_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic             sample_o,
    output logic             cmp_strobe,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    localparam int unsigned      IW          = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IW-1:0]    IDX_TOP     = IW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_TRIAL   = NBITS'(1) << (NBITS - 1);
    localparam logic [3:0]       SAMPLE_LOAD = 4'(SAMPLE_CYC - 1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    sar_state_t       state;
    sar_state_t       state_next;
    logic [IW-1:0]    idx;
    logic [NBITS-1:0] code;
    logic             tmr_load;
    logic [3:0]       tmr_val;
    logic             tmr_tc;

    sar_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // The timer is loaded on the edge entering a timed phase, so its
    // terminal count marks the last cycle of that phase.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        sample_o   = (state == SAMPLE);
        cmp_strobe = (state == COMPARE);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start || cont) begin
                    state_next = SAMPLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SAMPLE_LOAD;
                end
            end
            SAMPLE: begin
                if (tmr_tc) begin
                    state_next = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (tmr_tc) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (idx == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LOAD;
                end
            end
            DONE: begin
                if (cont) begin
                    state_next = SAMPLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SAMPLE_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= IDX_TOP;
            code         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                SAMPLE: begin
                    if (tmr_tc) begin
                        code <= MSB_TRIAL;
                        idx  <= IDX_TOP;
                    end
                end
                // Resolve the current bit and raise the next trial bit together.
                COMPARE: begin
                    code[idx] <= cmp_in;
                    if (idx != '0) begin
                        code[idx - 1'b1] <= 1'b1;
                        idx              <= idx - 1'b1;
                    end
                end
                DONE: code <= '0;
                default: ;
            endcase

            if (state == DONE) begin
                result       <= code;
                result_valid <= 1'b1;
                if (result_valid && !result_ready) begin
                    overrun <= 1'b1;
                end
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
                overrun      <= 1'b0;
            end
        end
    end

    assign dac_code = code;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with an ideal comparator (cmp_in = vin >= dac_code).
module tb_sar_adc_ctrl;

    localparam int NB     = 8;
    localparam int SC     = 2;
    localparam int TC     = 1;
    localparam int LAT    = SC + NB * (TC + 1) + 2;
    localparam int PERIOD = SC + NB * (TC + 1) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cont;
    logic          cmp_in;
    logic          sample_o;
    logic          cmp_strobe;
    logic [NB-1:0] dac_code;
    logic          busy;
    logic [NB-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          overrun;
    logic [NB-1:0] vin;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign cmp_in = (vin >= dac_code);

    sar_adc_ctrl #(
        .NBITS      (NB),
        .SAMPLE_CYC (SC),
        .SETTLE_CYC (TC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cont         (cont),
        .cmp_in       (cmp_in),
        .sample_o     (sample_o),
        .cmp_strobe   (cmp_strobe),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    typedef struct {
        logic [NB-1:0] vin;
        logic [NB-1:0] exp_res;
        int            hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single start-triggered conversion, then handshake after 'hold' cycles.
    task automatic convert(input logic [NB-1:0] v, input logic [NB-1:0] exp_res,
                           input int hold, input string tag);
        logic [NB-1:0] q[$];
        logic [NB-1:0] exp_tr[$];
        logic [NB-1:0] kept;
        logic [NB-1:0] trial;
        logic [NB-1:0] sdac;
        int            cyc;
        int            nsamp;
        kept = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            trial = kept | (NB'(1) << b);
            exp_tr.push_back(trial);
            if (v >= trial) kept = trial;
        end
        vin   = v;
        nsamp = 0;
        sdac  = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (cyc <= 100) begin
            if (sample_o) begin
                nsamp++;
                sdac |= dac_code;
            end
            if (cmp_strobe) q.push_back(dac_code);
            if (result_valid) break;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_ntrials"}, q.size(), NB);
        for (int i = 0; i < NB && i < q.size(); i++)
            check($sformatf("%s_trial%0d", tag, i), q[i], exp_tr[i]);
        check({tag, "_model"}, kept, exp_res);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_sample_cycles"}, nsamp, SC);
        check({tag, "_sample_dac"}, sdac, 0);
        check({tag, "_overrun"}, overrun, 0);
        for (int k = 0; k < hold; k++) @(negedge clk);
        check({tag, "_held_valid"}, result_valid, 1);
        check({tag, "_held_result"}, result, exp_res);
        result_ready = 1'b1;
        @(negedge clk) result_ready = 1'b0;
        check({tag, "_valid_clr"}, result_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        vec_t          tbl[7];
        logic [NB-1:0] v;
        logic [NB-1:0] kept;
        logic [NB-1:0] trial;
        int            n;
        int            cyc;
        int            nvalid;

        tbl[0] = '{8'hA5, 8'hA5, 0};
        tbl[1] = '{8'h00, 8'h00, 1};
        tbl[2] = '{8'hFF, 8'hFF, 0};
        tbl[3] = '{8'h3C, 8'h3C, 2};
        tbl[4] = '{8'h01, 8'h01, 0};
        tbl[5] = '{8'h80, 8'h80, 3};
        tbl[6] = '{8'h7F, 8'h7F, 0};

        rst = 1'b1; start = 1'b0; cont = 1'b0; result_ready = 1'b0; vin = '0;
        repeat (3) @(negedge clk);
        check("rst_dac", dac_code, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_sample", sample_o, 0);
        check("rst_strobe", cmp_strobe, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            convert(tbl[i].vin, tbl[i].exp_res, tbl[i].hold, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            v    = NB'($urandom_range(0, 255));
            kept = '0;
            for (int b = NB - 1; b >= 0; b--) begin
                trial = kept | (NB'(1) << b);
                if (v >= trial) kept = trial;
            end
            convert(v, kept, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        // Reset during the 4th COMPARE.
        vin = 8'hA5;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        for (cyc = 0; cyc < 100; cyc++) begin
            if (cmp_strobe) n++;
            if (n == 4) break;
            @(negedge clk);
        end
        check("midrst_strobes", n, 4);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_dac", dac_code, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_sample", sample_o, 0);
        check("midrst_strobe", cmp_strobe, 0);
        convert(8'h5A, 8'h5A, 1, "after_rst");

        // Start pulsed during SETTLE is ignored.
        vin = 8'h3C;
        result_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (busy && !sample_o && !cmp_strobe) break;
            @(negedge clk);
        end
        check("settle_found", busy && !sample_o && !cmp_strobe, 1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        nvalid = 0;
        for (cyc = 0; cyc < 60; cyc++) begin
            if (result_valid) nvalid++;
            @(negedge clk);
        end
        check("ignore_start_nresults", nvalid, 1);
        check("ignore_start_idle", busy, 0);
        check("ignore_start_result", result, 8'h3C);
        result_ready = 1'b0;

        // Continuous mode: handshake coincides with DONE.
        vin  = 8'h3C;
        cont = 1'b1;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (result_valid) break;
        end
        check("cont1_valid", result_valid, 1);
        check("cont1_result", result, 8'h3C);
        vin = 8'hC3;
        n   = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (cmp_strobe) n++;
            if (n == NB) break;
            @(negedge clk);
        end
        check("cont2_strobes", n, NB);
        @(negedge clk) result_ready = 1'b1;
        check("cont2_done_held", result, 8'h3C);
        @(negedge clk) result_ready = 1'b0;
        check("cont2_valid", result_valid, 1);
        check("cont2_result", result, 8'hC3);
        check("cont2_overrun", overrun, 0);
        cont = 1'b0;
        result_ready = 1'b1;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (!busy && !result_valid) break;
        end
        check("cont2_drained", busy || result_valid, 0);
        result_ready = 1'b0;

        // Continuous mode, never ready: second DONE overruns.
        vin  = 8'h3C;
        cont = 1'b1;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (result_valid) break;
        end
        check("ovr_first_valid", result_valid, 1);
        check("ovr_first_flag", overrun, 0);
        for (cyc = 0; cyc < 40; cyc++) begin
            if (overrun) break;
            @(negedge clk);
        end
        check("ovr_period", cyc, PERIOD);
        check("ovr_set", overrun, 1);
        check("ovr_result", result, 8'h3C);
        check("ovr_valid", result_valid, 1);
        cont = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("ovr_idle", busy, 0);
        check("ovr_sticky", overrun, 1);
        result_ready = 1'b1;
        @(negedge clk) result_ready = 1'b0;
        check("ovr_hs_valid", result_valid, 0);
        check("ovr_hs_clear", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 8: conversion resolution and width of dac_code and result.
REQ-002 SHALL have parameter SAMPLE_CYC, default 2: cycles in SAMPLE (legal range 1..15).
REQ-003 SHALL have parameter SETTLE_CYC, default 1: DAC settle cycles per bit trial (legal range 1..15).
REQ-004 SHALL have port clk, input, 1: single clock; every flop in the block is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: one-cycle conversion request; sampled only in IDLE.
REQ-007 SHALL have port cont, input, 1: continuous mode; restarts conversions back-to-back while high.
REQ-008 SHALL have port cmp_in, input, 1: comparator decision, 1 = Vin >= Vdac.
REQ-009 SHALL have port sample_o, output, 1: track switch, high only in SAMPLE.
REQ-010 SHALL have port cmp_strobe, output, 1: comparator latch, high only in COMPARE.
REQ-011 SHALL have port dac_code, output, NBITS: capacitive DAC trial code.
REQ-012 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-013 SHALL have port result, output, NBITS: last completed conversion.
REQ-014 SHALL have port result_valid, output, 1: valid half of the result handshake.
REQ-015 SHALL have port result_ready, input, 1: ready half of the result handshake.
REQ-016 SHALL have port overrun, output, 1: sticky flag, set when an unread result is overwritten.

Function
REQ-017 FSM states SHALL be IDLE, SAMPLE, SETTLE, COMPARE, DONE.
REQ-018 IDLE SHALL go to SAMPLE on the next edge when start=1 or cont=1; otherwise it stays in IDLE.
REQ-019 SAMPLE SHALL last exactly SAMPLE_CYC cycles with sample_o=1 and dac_code=0, then go to SETTLE with bit index = NBITS-1.
REQ-020 On entry to SETTLE, dac_code SHALL equal the kept bits above the index, with the trial bit at the index set and all lower bits 0.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to COMPARE.
REQ-022 COMPARE SHALL last 1 cycle with cmp_strobe=1; cmp_in SHALL be captured on the edge ending COMPARE.
REQ-023 Bit decision: captured cmp_in=1 keeps the trial bit; cmp_in=0 clears it.
REQ-024 After COMPARE, if index>0 the index SHALL decrement and the FSM return to SETTLE; if index=0 the FSM SHALL go to DONE.
REQ-025 DONE SHALL last 1 cycle: result is loaded with the final code and result_valid=1 from the next cycle.
REQ-026 After DONE the FSM SHALL go to SAMPLE if cont=1, else to IDLE.
REQ-027 Latency from the start edge to the first cycle of result_valid=1 SHALL be SAMPLE_CYC + NBITS*(SETTLE_CYC+1) + 2 cycles.
REQ-028 start while busy=1 SHALL be ignored, not queued.
REQ-029 Clearing cont mid-conversion SHALL let the current conversion finish, then return to IDLE.
REQ-030 result_valid SHALL hold, with result stable, until a cycle with result_valid=1 and result_ready=1; it SHALL then clear unless DONE loads in the same cycle.
REQ-031 DONE loading while result_valid=1 and result_ready=0 SHALL overwrite result, keep result_valid=1 and set overrun.
REQ-032 DONE loading in the same cycle as a handshake SHALL load the new result, keep result_valid=1 and leave overrun unchanged.
REQ-033 overrun SHALL clear only on a completed handshake that does not itself overrun, or on reset.
REQ-034 In IDLE, dac_code SHALL be 0, and sample_o and cmp_strobe SHALL be 0.

Reset
REQ-035 rst=1 at an edge SHALL force IDLE, index=NBITS-1, and outputs dac_code=0, result=0, result_valid=0, overrun=0, busy=0, sample_o=0, cmp_strobe=0, including mid-conversion.
REQ-036 No output SHALL change asynchronously to clk.

Structure
REQ-037 Shared package sar_pkg SHALL hold the state enum type and the default values of NBITS, SAMPLE_CYC and SETTLE_CYC.
REQ-038 One sub-module, sar_phase_timer (loadable 4-bit down-counter with terminal-count flag), SHALL time SAMPLE and SETTLE.
REQ-039 All control outputs SHALL be registered or decoded directly from the state register, with no path from cmp_in to any output.

Verification
REQ-040 Defaults, comparator model cmp_in=(0xA5>=dac_code), start pulse -> dac_code trials 80,C0,A0,B0,A8,A4,A6,A5; result=0xA5; result_valid 20 cycles after start.
REQ-041 Vin=0x00 and Vin=0xFF -> result=0x00 and 0xFF; no overrun.
REQ-042 cont=1, result_ready=0, Vin=0x3C -> second DONE sets overrun with result=0x3C; a later handshake leaves overrun set until the next handshake without overwrite.
REQ-043 cont=1 with result_ready pulsed in the DONE cycle -> result_valid stays 1, overrun stays 0.
REQ-044 rst asserted during the 4th COMPARE -> next cycle IDLE, dac_code=0, busy=0, result_valid=0; a fresh start converts correctly.
REQ-045 start pulsed during SETTLE -> ignored; exactly one result is produced and the FSM returns to IDLE.
